pc_fetch_block: RTL and testbench
=================================

Name: pc_fetch_block

Overview:
- Instruction-fetch stage sitting directly upstream of the jump control block.
- Holds the program counter and drives program-memory address/request.
- Latches the fetched instruction into the IF/ID register and presents current_address (address of the instruction now in IF/ID).
- Consumes jmp_loc/pc_mux_sel from the jump control block to redirect fetch, inserting bubbles on redirect, stall or memory wait.

Parameters:
- ADDR_W, 16, PC/address width.
- INSTR_W, 32, instruction width.
- RESET_VEC, 16'h0000, first fetch address after reset.
- FLUSH_CYCLES, 1, bubbles inserted per taken redirect (1..7).
- TIMEOUT, 64, max pm_ready-low cycles before fetch error (used only with optional feature).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- jmp_loc  in  ADDR_W  redirect target from jump control.
- pc_mux_sel  in  1  redirect request, sampled each cycle.
- stall  in  1  hazard hold from decode.
- pm_data  in  INSTR_W  program-memory read data.
- pm_ready  in  1  pm_data valid this cycle for pm_addr.
- pm_addr  out  ADDR_W  fetch address (= pc, combinational).
- pm_req  out  1  fetch request.
- instr_out  out  INSTR_W  IF/ID instruction.
- op  out  6  instr_out[INSTR_W-1:INSTR_W-6], to jump control.
- instr_valid  out  1  IF/ID holds a real instruction.
- current_address  out  ADDR_W  address of instr_out.
- fetch_err  out  1  sticky fetch timeout flag (0 without macro).

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_VEC, instr_out=0, instr_valid=0, current_address=0, fetch_err=0, flush_cnt=0, state=BOOT.
  - pm_req=0 while reset is low.
- States: BOOT, FETCH, WAIT, FLUSH.
- BOOT: one cycle after reset release, pm_req=0, then go to FETCH.
- pm_req = (state==FETCH or WAIT) & ~stall & ~pc_mux_sel.
- Priority each cycle: pc_mux_sel > stall > pm_ready.
- Redirect (pc_mux_sel=1, any state except BOOT):
  - pc<=jmp_loc, instr_out<=0, instr_valid<=0.
  - flush_cnt<=FLUSH_CYCLES-1.
  - state<=FLUSH if FLUSH_CYCLES>1, else FETCH.
  - Redirect during FLUSH restarts the count with the new target.
- stall=1 (no redirect):
  - pc, instr_out, instr_valid, current_address and state hold; pm_req=0.
- FETCH/WAIT with pm_ready=1:
  - instr_out<=pm_data, current_address<=pc, instr_valid<=1.
  - pc<=pc+1, wrapping from 16'hFFFF to 16'h0000.
  - state<=FETCH.
- FETCH/WAIT with pm_ready=0:
  - pc holds, instr_valid<=0 (bubble), state<=WAIT.
- FLUSH:
  - pm_req=0, instr_valid<=0, flush_cnt decrements.
  - At 0, state<=FETCH.
- Latency: the instruction at address A is in IF/ID one cycle after the cycle with pm_addr=A & pm_ready=1. A taken redirect yields FLUSH_CYCLES invalid cycles before the target instruction is valid.
- Simultaneous pc_mux_sel & pm_ready: fetched data is discarded and the redirect wins.
- Simultaneous stall & pc_mux_sel: the redirect wins.
- Reset mid-WAIT/FLUSH: immediate return to reset values; any outstanding pm_ready is ignored.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter increments each consecutive WAIT cycle.
  - On reaching TIMEOUT: fetch_err<=1 (sticky until reset), pc<=16'hF000, instr_valid<=0, state<=FETCH.
  - The counter clears on any pm_ready=1, redirect or stall.
- Undefined: no counter, fetch_err tied 0, WAIT persists indefinitely.

Test Plan:
- Reset low then high, pm_ready=1, pm_data=addr-tagged -> BOOT 1 cycle; pm_addr 0000,0001,0002; instr_valid rises the cycle after the first fetch; current_address follows 0000,0001.
- Preload pc=16'hFFFE, continuous fetch -> pm_addr FFFE,FFFF,0000; current_address wraps identically.
- pc_mux_sel=1, jmp_loc=16'h0040, with pm_ready=1 same cycle -> fetched data dropped; instr_valid=0 for 1 cycle; next pm_addr=0040; current_address=0040 with valid one cycle later. With FLUSH_CYCLES=3 -> 3 invalid cycles.
- stall=1 for 4 cycles while instr_valid=1 -> instr_out/current_address/pc frozen, pm_req=0. stall=1 with pc_mux_sel=1 -> redirect taken.
- pm_ready=0 for 5 cycles at pm_addr=0010 -> state WAIT, pc held at 0010, instr_valid=0; on pm_ready=1 the instruction lands with current_address=0010.
- Reset asserted mid-WAIT -> all outputs at reset values asynchronously. With FETCH_TIMEOUT_EN and TIMEOUT=64, pm_ready held 0 -> fetch_err=1 after 64 WAIT cycles; next pm_addr=F000.

Source files
------------

// File: rtl/pc_fetch_block_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_block_if
// Purpose : groups the fetch stage's jump-control, hazard, program-memory and
//           IF/ID signals into one bundle.
// Modports:
//   master - used by pc_fetch_block (drives pm_addr/pm_req and the IF/ID
//            outputs, receives redirect, stall and memory data)
//   slave  - used by the surrounding pipeline / memory model
// Signals :
//   jmp_loc[ADDR_W]    redirect target          pc_mux_sel  redirect request
//   stall              decode hazard hold        pm_data[INSTR_W] memory data
//   pm_ready           pm_data valid for pm_addr pm_addr[ADDR_W] fetch address
//   pm_req             fetch request             instr_out[INSTR_W] IF/ID instr
//   op[6]              opcode field of instr_out instr_valid IF/ID holds real instr
//   current_address    address of instr_out      fetch_err   sticky timeout flag
// ---------------------------------------------------------------------------
interface pc_fetch_block_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  jmp_loc;
    logic               pc_mux_sel;
    logic               stall;
    logic [INSTR_W-1:0] pm_data;
    logic               pm_ready;
    logic [ADDR_W-1:0]  pm_addr;
    logic               pm_req;
    logic [INSTR_W-1:0] instr_out;
    logic [5:0]         op;
    logic               instr_valid;
    logic [ADDR_W-1:0]  current_address;
    logic               fetch_err;

    modport master (
        input  jmp_loc, pc_mux_sel, stall, pm_data, pm_ready,
        output pm_addr, pm_req, instr_out, op, instr_valid, current_address, fetch_err
    );

    modport slave (
        output jmp_loc, pc_mux_sel, stall, pm_data, pm_ready,
        input  pm_addr, pm_req, instr_out, op, instr_valid, current_address, fetch_err
    );
endinterface

// File: rtl/pc_fetch_block.sv
// ---------------------------------------------------------------------------
// pc_fetch_block
// Purpose : instruction-fetch stage. Holds the program counter, drives the
//           program-memory request, latches fetched instructions into the
//           IF/ID register and redirects on requests from jump control,
//           inserting bubbles on redirect, stall or memory wait.
// Ports   :
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous, active-low reset
//   bus    - pc_fetch_block_if.master (redirect, stall, program memory, IF/ID)
// Options :
//   FETCH_TIMEOUT_EN - when defined, a WAIT that lasts TIMEOUT cycles raises
//                      the sticky fetch_err flag and restarts fetch at 0xF000.
//                      When undefined, fetch_err is tied low and WAIT may last
//                      indefinitely.
// ---------------------------------------------------------------------------
module pc_fetch_block #(
    parameter int              ADDR_W       = 16,
    parameter int              INSTR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int              FLUSH_CYCLES = 1,
    parameter int              TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    pc_fetch_block_if.master  bus
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // Elaboration-time parameter sanity checks.
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
        $error("pc_fetch_block: FLUSH_CYCLES must be in 1..7");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("pc_fetch_block: TIMEOUT must be at least 1");
    end
    if (INSTR_W < 6) begin : g_bad_instr_w
        $error("pc_fetch_block: INSTR_W must be at least 6");
    end

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic [ADDR_W-1:0]  r_cur_addr;
    logic [1:0]         r_state;
    logic [2:0]         r_flush_cnt;

    logic [ADDR_W-1:0]  w_pc_next;
    logic [INSTR_W-1:0] w_instr_next;
    logic               w_valid_next;
    logic [ADDR_W-1:0]  w_cur_addr_next;
    logic [1:0]         w_state_next;
    logic [2:0]         w_flush_cnt_next;
    logic               w_fetching;

`ifdef FETCH_TIMEOUT_EN
    localparam int               WAIT_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ERR_VEC   = ADDR_W'(16'hF000);

    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_next;
    logic                  r_fetch_err;
    logic                  w_fetch_err_next;
`endif

    assign w_fetching = (r_state == ST_FETCH) || (r_state == ST_WAIT);

    // The request is withdrawn combinationally when a stall or redirect is
    // present, so memory never sees a request for an address about to be
    // abandoned.
    assign bus.pm_req          = w_fetching & ~bus.stall & ~bus.pc_mux_sel;
    assign bus.pm_addr         = r_pc;
    assign bus.instr_out       = r_instr;
    assign bus.op              = r_instr[INSTR_W-1 -: 6];
    assign bus.instr_valid     = r_valid;
    assign bus.current_address = r_cur_addr;

`ifdef FETCH_TIMEOUT_EN
    assign bus.fetch_err = r_fetch_err;
`else
    assign bus.fetch_err = 1'b0;
`endif

    always_comb begin
        w_pc_next        = r_pc;
        w_instr_next     = r_instr;
        w_valid_next     = r_valid;
        w_cur_addr_next  = r_cur_addr;
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
`ifdef FETCH_TIMEOUT_EN
        // Cleared unless the WAIT branch below extends the run.
        w_wait_cnt_next  = '0;
        w_fetch_err_next = r_fetch_err;
`endif

        if (r_state == ST_BOOT) begin
            // Single idle cycle after reset release; redirects are not
            // accepted until fetch is running.
            w_state_next = ST_FETCH;
        end else if (bus.pc_mux_sel) begin
            // Redirect wins over stall and over any data arriving this cycle.
            w_pc_next        = bus.jmp_loc;
            w_instr_next     = '0;
            w_valid_next     = 1'b0;
            w_flush_cnt_next = 3'(FLUSH_CYCLES - 1);
            w_state_next     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_FETCH;
        end else if (bus.stall) begin
            // Hold everything; defaults already do that.
        end else if (r_state == ST_FLUSH) begin
            w_valid_next = 1'b0;
            // Leave FLUSH as the count reaches zero so the redirect cycle plus
            // the flush cycles total FLUSH_CYCLES bubbles.
            if (r_flush_cnt <= 3'd1) begin
                w_flush_cnt_next = '0;
                w_state_next     = ST_FETCH;
            end else begin
                w_flush_cnt_next = r_flush_cnt - 3'd1;
            end
        end else if (bus.pm_ready) begin
            w_instr_next    = bus.pm_data;
            w_cur_addr_next = r_pc;
            w_valid_next    = 1'b1;
            w_pc_next       = r_pc + 1'b1;
            w_state_next    = ST_FETCH;
        end else begin
            w_valid_next = 1'b0;
            w_state_next = ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
            // Only cycles already in WAIT count toward the timeout.
            if (r_state == ST_WAIT) begin
                if (r_wait_cnt == WAIT_CNT_W'(TIMEOUT - 1)) begin
                    w_fetch_err_next = 1'b1;
                    w_pc_next        = ERR_VEC;
                    w_state_next     = ST_FETCH;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_VEC;
            r_instr     <= '0;
            r_valid     <= 1'b0;
            r_cur_addr  <= '0;
            r_state     <= ST_BOOT;
            r_flush_cnt <= '0;
        end else begin
            r_pc        <= w_pc_next;
            r_instr     <= w_instr_next;
            r_valid     <= w_valid_next;
            r_cur_addr  <= w_cur_addr_next;
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_wait_cnt  <= w_wait_cnt_next;
            r_fetch_err <= w_fetch_err_next;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_block.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_block
// Directed bench for pc_fetch_block. Two instances share the same stimulus:
// u_dut uses FLUSH_CYCLES=1, u_dut3 uses FLUSH_CYCLES=3. Program memory is
// modelled as always returning {16'h1234, pm_addr}, so every fetched word
// carries its own address and op = 6'd4.
// ---------------------------------------------------------------------------
module tb_pc_fetch_block;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] jmp_loc;
    logic        pc_mux_sel;
    logic        stall;
    logic        pm_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_block_if #(.ADDR_W(16), .INSTR_W(32)) bus1 ();
    pc_fetch_block_if #(.ADDR_W(16), .INSTR_W(32)) bus3 ();

    assign bus1.jmp_loc    = jmp_loc;
    assign bus1.pc_mux_sel = pc_mux_sel;
    assign bus1.stall      = stall;
    assign bus1.pm_ready   = pm_ready;
    assign bus1.pm_data    = {16'h1234, bus1.pm_addr};

    assign bus3.jmp_loc    = jmp_loc;
    assign bus3.pc_mux_sel = pc_mux_sel;
    assign bus3.stall      = stall;
    assign bus3.pm_ready   = pm_ready;
    assign bus3.pm_data    = {16'h1234, bus3.pm_addr};

    pc_fetch_block #(
        .ADDR_W(16), .INSTR_W(32), .RESET_VEC(16'h0000),
        .FLUSH_CYCLES(1), .TIMEOUT(64)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus1.master)
    );

    pc_fetch_block #(
        .ADDR_W(16), .INSTR_W(32), .RESET_VEC(16'h0000),
        .FLUSH_CYCLES(3), .TIMEOUT(64)
    ) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3.master)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        jmp_loc    = 16'h0000;
        pc_mux_sel = 1'b0;
        stall      = 1'b0;
        pm_ready   = 1'b1;
        #2 reset = 1'b0;
        step();
        step();

        // Reset state
        check_val("rst_pm_addr", 32'(bus1.pm_addr), 32'h0000);
        check_val("rst_pm_req", 32'(bus1.pm_req), 32'h0);
        check_val("rst_valid", 32'(bus1.instr_valid), 32'h0);
        check_val("rst_instr", bus1.instr_out, 32'h0);
        check_val("rst_cur", 32'(bus1.current_address), 32'h0);
        check_val("rst_err", 32'(bus1.fetch_err), 32'h0);

        // Release: one BOOT cycle with no request
        reset = 1'b1;
        #1;
        check_val("boot_pm_req", 32'(bus1.pm_req), 32'h0);
        step();
        check_val("fetch0_pm_req", 32'(bus1.pm_req), 32'h1);
        check_val("fetch0_pm_addr", 32'(bus1.pm_addr), 32'h0000);
        check_val("fetch0_valid", 32'(bus1.instr_valid), 32'h0);
        step();
        check_val("if0_valid", 32'(bus1.instr_valid), 32'h1);
        check_val("if0_cur", 32'(bus1.current_address), 32'h0000);
        check_val("if0_instr", bus1.instr_out, 32'h1234_0000);
        check_val("if0_op", 32'(bus1.op), 32'h4);
        check_val("if0_pm_addr", 32'(bus1.pm_addr), 32'h0001);
        step();
        check_val("if1_cur", 32'(bus1.current_address), 32'h0001);
        check_val("if1_pm_addr", 32'(bus1.pm_addr), 32'h0002);

        // Redirect to FFFE, then fetch across the wrap
        jmp_loc    = 16'hFFFE;
        pc_mux_sel = 1'b1;
        #1;
        check_val("redir_pm_req", 32'(bus1.pm_req), 32'h0);
        step();
        pc_mux_sel = 1'b0;
        check_val("redirA_valid", 32'(bus1.instr_valid), 32'h0);
        check_val("redirA_instr", bus1.instr_out, 32'h0);
        check_val("redirA_pm_addr", 32'(bus1.pm_addr), 32'hFFFE);
        step();
        check_val("wrap_cur_fffe", 32'(bus1.current_address), 32'hFFFE);
        check_val("wrap_pm_ffff", 32'(bus1.pm_addr), 32'hFFFF);
        step();
        check_val("wrap_cur_ffff", 32'(bus1.current_address), 32'hFFFF);
        check_val("wrap_pm_0000", 32'(bus1.pm_addr), 32'h0000);
        step();
        check_val("wrap_cur_0000", 32'(bus1.current_address), 32'h0000);
        check_val("wrap_pm_0001", 32'(bus1.pm_addr), 32'h0001);

        // Redirect to 0040 while pm_ready=1: fetched word dropped
        jmp_loc    = 16'h0040;
        pc_mux_sel = 1'b1;
        step();
        pc_mux_sel = 1'b0;
        check_val("j40_valid", 32'(bus1.instr_valid), 32'h0);
        check_val("j40_pm_addr", 32'(bus1.pm_addr), 32'h0040);
        check_val("j40_f3_valid0", 32'(bus3.instr_valid), 32'h0);
        check_val("j40_f3_pm_req", 32'(bus3.pm_req), 32'h0);
        step();
        check_val("j40_valid_on", 32'(bus1.instr_valid), 32'h1);
        check_val("j40_cur", 32'(bus1.current_address), 32'h0040);
        check_val("j40_f3_valid1", 32'(bus3.instr_valid), 32'h0);
        step();
        check_val("j40_f3_valid2", 32'(bus3.instr_valid), 32'h0);
        check_val("j40_f3_pm_addr", 32'(bus3.pm_addr), 32'h0040);
        step();
        check_val("j40_f3_valid_on", 32'(bus3.instr_valid), 32'h1);
        check_val("j40_f3_cur", 32'(bus3.current_address), 32'h0040);
        check_val("j40_cur_0042", 32'(bus1.current_address), 32'h0042);

        // Stall for 4 cycles with a valid instruction in IF/ID
        stall = 1'b1;
        #1;
        check_val("stall_pm_req", 32'(bus1.pm_req), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("stall%0d_cur", i), 32'(bus1.current_address), 32'h0042);
            check_val($sformatf("stall%0d_pc", i), 32'(bus1.pm_addr), 32'h0043);
            check_val($sformatf("stall%0d_instr", i), bus1.instr_out, 32'h1234_0042);
            check_val($sformatf("stall%0d_valid", i), 32'(bus1.instr_valid), 32'h1);
        end

        // Stall together with redirect: redirect taken
        jmp_loc    = 16'h0010;
        pc_mux_sel = 1'b1;
        step();
        pc_mux_sel = 1'b0;
        stall      = 1'b0;
        pm_ready   = 1'b0;
        check_val("stallj_pm_addr", 32'(bus1.pm_addr), 32'h0010);
        check_val("stallj_valid", 32'(bus1.instr_valid), 32'h0);

        // Memory wait for 5 cycles at 0010
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("wait%0d_pc", i), 32'(bus1.pm_addr), 32'h0010);
            check_val($sformatf("wait%0d_valid", i), 32'(bus1.instr_valid), 32'h0);
            check_val($sformatf("wait%0d_req", i), 32'(bus1.pm_req), 32'h1);
        end
        pm_ready = 1'b1;
        step();
        check_val("waitdone_valid", 32'(bus1.instr_valid), 32'h1);
        check_val("waitdone_cur", 32'(bus1.current_address), 32'h0010);
        check_val("waitdone_instr", bus1.instr_out, 32'h1234_0010);
        check_val("waitdone_pm_addr", 32'(bus1.pm_addr), 32'h0011);

        // Reset asserted mid-WAIT, between clock edges
        pm_ready = 1'b0;
        step();
        step();
        check_val("prerst_valid", 32'(bus1.instr_valid), 32'h0);
        check_val("prerst_cur", 32'(bus1.current_address), 32'h0010);
        reset = 1'b0;
        #1;
        check_val("arst_pm_addr", 32'(bus1.pm_addr), 32'h0000);
        check_val("arst_cur", 32'(bus1.current_address), 32'h0000);
        check_val("arst_instr", bus1.instr_out, 32'h0);
        check_val("arst_valid", 32'(bus1.instr_valid), 32'h0);
        check_val("arst_pm_req", 32'(bus1.pm_req), 32'h0);
        pm_ready = 1'b1;
        step();
        check_val("arst_ready_ignored", 32'(bus1.instr_valid), 32'h0);
        check_val("arst_cur_hold", 32'(bus1.current_address), 32'h0000);

`ifdef FETCH_TIMEOUT_EN
        // Timeout: BOOT, FETCH->WAIT, then 64 WAIT cycles before the flag
        begin
            int n;
            n = 0;
            pm_ready = 1'b0;
            reset    = 1'b1;
            while (bus1.fetch_err !== 1'b1 && n < 200) begin
                step();
                n++;
            end
            check_val("tmo_cycles", 32'(n), 32'd66);
            check_val("tmo_err", 32'(bus1.fetch_err), 32'h1);
            check_val("tmo_pm_addr", 32'(bus1.pm_addr), 32'hF000);
            check_val("tmo_valid", 32'(bus1.instr_valid), 32'h0);
        end
`else
        // Without the timeout option WAIT persists and fetch_err stays low
        pm_ready = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 80; i++) step();
        check_val("notmo_err", 32'(bus1.fetch_err), 32'h0);
        check_val("notmo_pm_addr", 32'(bus1.pm_addr), 32'h0000);
        check_val("notmo_pm_req", 32'(bus1.pm_req), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
